// File: rtl/shifter_2d_mc_if.sv
// shifter_2d_mc_if: control, data and status bundle of the multi-channel tapped delay line
interface shifter_2d_mc_if #(
  parameter int TAMANYO = 32,
  parameter int SIZE    = 8,
  parameter int CANALES = 2
);
  localparam int SW = $clog2(TAMANYO);
  localparam int OW = $clog2(TAMANYO + 1);
  logic                      enable;
  logic                      clear;
  logic [1:0]                modo;
  logic [SW-1:0]             seleccion;
  logic [CANALES*SIZE-1:0]   entrada_serie;
  logic [CANALES*SIZE-1:0]   salida_serie;
  logic                      valido;
  logic [OW-1:0]             ocupacion;
  logic                      lleno;
  modport master (
    output enable, clear, modo, seleccion, entrada_serie,
    input  salida_serie, valido, ocupacion, lleno
  );
  modport slave (
    input  enable, clear, modo, seleccion, entrada_serie,
    output salida_serie, valido, ocupacion, lleno
  );
endinterface

// File: rtl/shifter_2d_mc.sv
// shifter_2d_mc: multi-lane tapped delay line with rotate mode, shared validity and occupancy
module shifter_2d_mc #(
  parameter int TAMANYO = 32,
  parameter int SIZE    = 8,
  parameter int CANALES = 2
) (
  input logic             clock,
  input logic             reset,
  shifter_2d_mc_if.slave  bus
);
  localparam int SW = $clog2(TAMANYO);
  localparam int OW = $clog2(TAMANYO + 1);
  logic [SIZE-1:0]    aux_q [CANALES][TAMANYO];
  logic [SIZE-1:0]    aux_d [CANALES][TAMANYO];
  logic [TAMANYO-1:0] v_q, v_d;
  logic [SW-1:0]      k;
  logic               in_range;
  logic [OW-1:0]      occ;
  // next state: clear beats enable; stage 0 takes the new sample or the recirculated last stage
  always_comb begin
    aux_d = aux_q;
    v_d   = v_q;
    if (!bus.clear) begin
      aux_d = '{default: '0};
      v_d   = '0;
    end else if (bus.enable) begin
      for (int c = 0; c < CANALES; c++) begin
        aux_d[c][0] = bus.modo[1] ? aux_q[c][TAMANYO-1] : bus.entrada_serie[c*SIZE +: SIZE];
        for (int i = 1; i < TAMANYO; i++) aux_d[c][i] = aux_q[c][i-1];
      end
      v_d = {v_q[TAMANYO-2:0], bus.modo[1] ? v_q[TAMANYO-1] : 1'b1};
    end
  end
  // state register with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aux_q <= '{default: '0};
      v_q   <= '0;
    end else begin
      aux_q <= aux_d;
      v_q   <= v_d;
    end
  end
  // tap selection; an index past the last stage (non power-of-two depth) reads as empty
  always_comb begin
    k        = bus.modo[0] ? bus.seleccion : SW'(TAMANYO - 1);
    in_range = {1'b0, k} < (SW + 1)'(TAMANYO);
    bus.salida_serie = '0;
    for (int c = 0; c < CANALES; c++)
      bus.salida_serie[c*SIZE +: SIZE] = in_range ? aux_q[c][k] : '0;
    bus.valido = in_range && v_q[k];
  end
  // occupancy as a population count of the shared valid vector
  always_comb begin
    occ = '0;
    for (int i = 0; i < TAMANYO; i++) occ = occ + OW'(v_q[i]);
    bus.ocupacion = occ;
    bus.lleno     = &v_q;
  end
endmodule

// File: tb/tb_shifter_2d_mc.sv
// tb_shifter_2d_mc: scoreboard bench with a queue-based reference model of the delay line
module tb_shifter_2d_mc;
  localparam int T  = 32;
  localparam int SZ = 8;
  localparam int CH = 2;
  localparam int W  = CH * SZ;
  typedef logic [W-1:0] word_t;
  typedef struct {
    word_t s;
    bit    v;
    int    occ;
    bit    l;
  } exp_t;
  logic clock = 0;
  logic reset = 1;
  int checks = 0;
  int passes = 0;
  word_t mq[$];
  bit    vq[$];
  exp_t  sb[$];
  word_t first20;
  always #5 clock = ~clock;
  shifter_2d_mc_if #(.TAMANYO(T), .SIZE(SZ), .CANALES(CH)) bus ();
  shifter_2d_mc #(.TAMANYO(T), .SIZE(SZ), .CANALES(CH)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  shifter_2d_mc_if #(.TAMANYO(20), .SIZE(SZ), .CANALES(CH)) b20 ();
  shifter_2d_mc #(.TAMANYO(20), .SIZE(SZ), .CANALES(CH)) u20 (
    .clock(clock), .reset(reset), .bus(b20)
  );
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
  endtask
  task automatic model_clear();
    mq = {};
    vq = {};
    repeat (T) begin
      mq.push_back('0);
      vq.push_back(1'b0);
    end
  endtask
  task automatic model_edge();
    word_t w;
    bit b;
    if (!bus.clear) model_clear();
    else if (bus.enable) begin
      w = mq.pop_back();
      b = vq.pop_back();
      if (bus.modo[1]) begin
        mq.push_front(w);
        vq.push_front(b);
      end else begin
        mq.push_front(bus.entrada_serie);
        vq.push_front(1'b1);
      end
    end
  endtask
  task automatic push_exp();
    exp_t e;
    int k;
    k = bus.modo[0] ? int'(bus.seleccion) : T - 1;
    e.s = (k < T) ? mq[k] : '0;
    e.v = (k < T) ? vq[k] : 1'b0;
    e.occ = 0;
    foreach (vq[i]) e.occ += vq[i];
    e.l = (e.occ == T);
    sb.push_back(e);
  endtask
  task automatic cyc(bit e, bit c, logic [1:0] m, int s, word_t d);
    @(posedge clock);
    if (!reset) model_edge();
    #1;
    bus.enable = e;
    bus.clear = c;
    bus.modo = m;
    bus.seleccion = 5'(s);
    bus.entrada_serie = d;
    push_exp();
  endtask
  task automatic async_reset();
    @(posedge clock);
    if (!reset) model_edge();
    #3;
    reset = 1;
    bus.enable = 1'($urandom);
    bus.clear = 1'($urandom);
    bus.modo = 2'($urandom);
    bus.seleccion = 5'($urandom);
    bus.entrada_serie = W'($urandom);
    model_clear();
    push_exp();
    @(negedge clock);
    #1 reset = 0;
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("salida_serie", 32'(bus.salida_serie), 32'(e.s));
      chk("valido", 32'(bus.valido), 32'(e.v));
      chk("ocupacion", 32'(bus.ocupacion), 32'(e.occ));
      chk("lleno", 32'(bus.lleno), 32'(e.l));
    end
  end
  initial begin
    bus.enable = 0;
    bus.clear = 1;
    bus.modo = 0;
    bus.seleccion = 0;
    bus.entrada_serie = 0;
    b20.enable = 0;
    b20.clear = 1;
    b20.modo = 0;
    b20.seleccion = 0;
    b20.entrada_serie = 0;
    model_clear();
    async_reset();
    cyc(1, 0, 2'b00, 0, '0);
    for (int i = 1; i <= 33; i++) begin
      cyc(1, 1, 2'b00, 0, {8'(8'h80 + i), 8'(i)});
      #1;
      if (i == 32) begin
        chk("fill31_occ", 32'(bus.ocupacion), 31);
        chk("fill31_valido", 32'(bus.valido), 0);
      end
      if (i == 33) begin
        chk("fill32_out", 32'(bus.salida_serie), 32'h8101);
        chk("fill32_lleno", 32'(bus.lleno), 1);
      end
    end
    cyc(0, 1, 2'b00, 0, '0);
    #1;
    chk("fill33_out", 32'(bus.salida_serie), 32'h8202);
    chk("fill33_occ", 32'(bus.ocupacion), 32);
    for (int i = 0; i < 6; i++) cyc(1, 1, 2'b00, 0, W'($urandom));
    async_reset();
    cyc(1, 0, 2'b00, 0, '0);
    for (int i = 1; i <= 5; i++) cyc(1, 1, 2'b00, 0, {8'(8'h80 + i), 8'(i)});
    cyc(0, 1, 2'b01, 4, '0);
    #1 chk("tap4", 32'(bus.salida_serie[7:0]), 32'h01);
    chk("tap4_valido", 32'(bus.valido), 1);
    cyc(0, 1, 2'b01, 0, '0);
    #1 chk("tap0", 32'(bus.salida_serie[7:0]), 32'h05);
    cyc(0, 1, 2'b01, 5, '0);
    #1 chk("tap5", 32'(bus.salida_serie), 0);
    chk("tap5_valido", 32'(bus.valido), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 2'($urandom), $urandom_range(0, T - 1), W'($urandom));
      repeat (3) cyc(0, 1, 2'($urandom), $urandom_range(0, T - 1), W'($urandom));
    end
    for (int i = 0; i < T; i++) cyc(1, 1, 2'b00, 0, W'($urandom));
    for (int i = 0; i < T; i++) cyc(1, 1, 2'b10, $urandom_range(0, T - 1), W'($urandom));
    cyc(1, 0, 2'b00, 0, '0);
    for (int i = 1; i <= 3; i++) cyc(1, 1, 2'b00, 0, {8'(8'h80 + i), 8'(i)});
    for (int i = 0; i < 29; i++) cyc(1, 1, 2'b10, 0, W'($urandom));
    cyc(0, 1, 2'b00, 0, '0);
    #1 chk("rot29_out", 32'(bus.salida_serie), 32'h8101);
    chk("rot29_occ", 32'(bus.ocupacion), 3);
    for (int i = 0; i < 10; i++) cyc(1, 1, 2'b00, 0, W'($urandom));
    cyc(1, 0, 2'b00, 0, 16'h5555);
    cyc(0, 1, 2'b00, 0, '0);
    #1 chk("clear_occ", 32'(bus.ocupacion), 0);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom), ($urandom_range(0, 30) != 0), 2'($urandom),
          $urandom_range(0, T - 1), W'($urandom));
    cyc(0, 1, 2'b00, 0, '0);
    @(posedge clock);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      b20.enable = 1;
      b20.entrada_serie = W'($urandom);
      if (i == 0) first20 = b20.entrada_serie;
    end
    @(posedge clock);
    #1;
    b20.enable = 0;
    b20.modo = 2'b01;
    b20.seleccion = 5'd25;
    #1 chk("t20_sel25_out", 32'(b20.salida_serie), 0);
    chk("t20_sel25_valido", 32'(b20.valido), 0);
    chk("t20_lleno", 32'(b20.lleno), 1);
    b20.seleccion = 5'd19;
    #1 chk("t20_sel19_out", 32'(b20.salida_serie), 32'(first20));
    chk("t20_sel19_valido", 32'(b20.valido), 1);
    @(negedge clock);
    #1;
    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/shifter_2d_mc.md
# shifter_2d_mc

Multi-channel tapped delay line, successor to the single-lane 2-D shifter. Holds `CANALES` parallel lanes of `TAMANYO` stages × `SIZE` bits, all advancing together on `enable`. Adds:
- a recirculation (rotate) mode;
- per-stage validity tracking, so consumers know when a tap holds real data rather than reset zeros;
- occupancy and full flags.

Sits in the multiplier datapath wherever operand words must be delayed or re-read a programmable number of steps later.

## Interface
- `TAMANYO`, 32: stages per lane (depth), ≥2.
- `SIZE`, 8: bits per stage.
- `CANALES`, 2: number of parallel lanes, ≥1.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  advance all lanes one stage this edge.
- `clear`  in  1  synchronous clear, active-low.
- `modo`  in  2  bit0: output select (0 = last stage, 1 = `seleccion` tap); bit1: input source (0 = `entrada_serie`, 1 = recirculate last stage).
- `seleccion`  in  $clog2(TAMANYO)  tap index for `modo[0]=1`; 0 = newest stage.
- `entrada_serie`  in  CANALES*SIZE  lane c on bits [c*SIZE +: SIZE].
- `salida_serie`  out  CANALES*SIZE  selected stage per lane, same packing.
- `valido`  out  1  selected stage holds a valid sample.
- `ocupacion`  out  $clog2(TAMANYO+1)  number of valid stages.
- `lleno`  out  1  all `TAMANYO` stages valid.

## Operation
State:
- data array `aux[c][0..TAMANYO-1]`;
- one shared valid vector `v[0..TAMANYO-1]`. All lanes share validity.

Clock-edge update, priority order:
1. `reset=1` (async): all `aux` = 0, `v` = 0.
2. `clear=0`: all `aux` = 0, `v` = 0. Overrides `enable` and `modo`.
3. `enable=1`, `modo[1]=0` (shift):
   - `aux[c][0]` ← lane c of `entrada_serie`; `aux[c][i]` ← `aux[c][i-1]`.
   - `v[0]` ← 1; `v[i]` ← `v[i-1]`.
   - Last stage discarded.
4. `enable=1`, `modo[1]=1` (rotate):
   - `aux[c][0]` ← `aux[c][TAMANYO-1]`, remaining stages shift as in shift mode.
   - `v` rotates identically, so population is preserved.
   - `entrada_serie` ignored.
5. `enable=0`: hold.

Outputs (combinational from state):
- Effective index `k` = `seleccion` if `modo[0]=1`, else `TAMANYO-1`.
- `salida_serie` lane c = `aux[c][k]`; `valido` = `v[k]`.
- If `seleccion ≥ TAMANYO` (non-power-of-two depth) and `modo[0]=1`: `salida_serie` = 0, `valido` = 0.
- `ocupacion` = popcount(`v`); `lleno` = &`v`.
- All outputs are 0 while reset is asserted and after reset/clear.

## Timing
- Single clock domain; all state changes on the rising `clock` edge, except reset.
- Reset:
  - Asserting `reset` zeroes state immediately, mid-operation included.
  - The first edge with `reset=0` may already shift.
- Latency:
  - A sample written at enabled edge n appears at tap k after edge n+k.
  - At the last stage (`modo[0]=0`) it appears after `TAMANYO-1` further enabled edges, i.e. it is the oldest of `TAMANYO` samples.
  - Disabled cycles do not count.
- `modo` and `seleccion` may change any cycle:
  - Output-select changes take effect combinationally.
  - Input-source changes take effect on the next enabled edge.
- Occupancy: `ocupacion` saturates at `TAMANYO` in shift mode and is constant in rotate mode.
- Recirculation: `TAMANYO` consecutive rotate edges restore the original `aux` and `v`.
- Simultaneous `clear=0` and `enable=1`: clear wins; `entrada_serie` is dropped.

## Test plan
Defaults `TAMANYO=32`, `SIZE=8`, `CANALES=2`.
- Reset: pulse `reset` with random inputs → `salida_serie=0`, `valido=0`, `ocupacion=0`, `lleno=0`. Assert `reset` mid-stream → same values before the next edge.
- Fill, `modo=00`, `enable` every cycle, lane0 = 0x01..0x20, lane1 = 0x81..0xA0:
  - after edge 31: `ocupacion=31`, `valido=0`;
  - after edge 32: `salida_serie={0x81,0x01}`, `valido=1`, `lleno=1`;
  - edge 33 with 0x21/0xA1 → `{0x82,0x02}`, `ocupacion` stays 32.
- Tap: after 5 samples 0x01..0x05, `modo=01`:
  - `seleccion=4` → lane0 0x01, `valido=1`;
  - `seleccion=0` → 0x05;
  - `seleccion=5` → 0x00, `valido=0`.
  - Build `TAMANYO=20`, `seleccion=25` → 0, `valido=0`.
- Enable gaps: interleave 3 idle cycles between samples → `ocupacion` advances only on enabled edges; outputs hold across gaps.
- Rotate:
  - Fill 32 samples, then `modo=10` for 32 edges → contents identical to before, `lleno=1` throughout.
  - Alternatively, 3 samples 0x01..0x03 then 29 rotate edges → last stage = 0x01, `valido=1`, `ocupacion=3`.
- Clear: mid-fill, drive `clear=0` with `enable=1` and input 0x55 → next cycle all outputs 0, `ocupacion=0`. The following enabled edge puts 0x55… only if re-driven.
